l1d_mshr_alloc: RTL and testbench

Allocation controller for the L1D miss-status holding register pool. Tracks a busy bitmap of MSHR entries, grants entries to two requesters (load pipe, store pipe) through valid/ready handshakes, returns released entries, and reports the live free-entry count. Sits between the L1D pipeline miss path and the MSHR storage array.

---
 rtl/l1d_mshr_pkg.sv | 17 +
 rtl/l1d_mshr_alloc_one_counter.sv | 17 +
 rtl/l1d_mshr_alloc.sv | 127 ++++++++++++
 tb/tb_l1d_mshr_alloc.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/l1d_mshr_pkg.sv
// Shared constants and width helpers for the L1D MSHR allocation slice.
package l1d_mshr_pkg;

  localparam int unsigned N_ENTRY_DEF = 8;
  localparam int unsigned N_REQ       = 2;
  localparam int unsigned REQ_LD      = 0;
  localparam int unsigned REQ_ST      = 1;

  function automatic int unsigned calc_id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned calc_cnt_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/l1d_mshr_alloc_one_counter.sv
// Population count of a bit vector; used for the MSHR free-entry count.
module one_counter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_W      = $clog2(DATA_WIDTH) + 1
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [CNT_W-1:0]      count_o
);

  always_comb begin
    count_o = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      count_o = count_o + CNT_W'(data_i[i]);
    end
  end

endmodule

// File: rtl/l1d_mshr_alloc.sv
// MSHR pool allocator: busy bitmap, dual-requester grant with round-robin
// tie-break when one entry is left, entry release and sticky release error.
module l1d_mshr_alloc
  import l1d_mshr_pkg::*;
#(
  parameter  int unsigned N_ENTRY = N_ENTRY_DEF,
  localparam int unsigned ID_W    = calc_id_w(N_ENTRY),
  localparam int unsigned CNT_W   = calc_cnt_w(N_ENTRY)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [1:0]           alloc_vld_i,
  output logic [1:0]           alloc_rdy_o,
  output logic [2*ID_W-1:0]    alloc_id_o,
  input  logic                 rel_vld_i,
  input  logic [ID_W-1:0]      rel_id_i,
  output logic [CNT_W-1:0]     free_cnt_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 rel_err_o
);

  logic [N_ENTRY-1:0] busy;
  logic [N_ENTRY-1:0] busy_nxt;
  logic [N_ENTRY-1:0] free_vec;
  logic [N_ENTRY-1:0] grant_oh;
  logic [N_ENTRY-1:0] rel_oh;
  logic               rr_ptr;
  logic               rr_nxt;
  logic               rel_err;
  logic               rel_hit;
  logic               both_vld;
  logic [ID_W-1:0]    f0;
  logic [ID_W-1:0]    f1;
  logic               f0_ok;
  logic               f1_ok;
  logic [ID_W-1:0]    id_ld;
  logic [ID_W-1:0]    id_st;
  logic [1:0]         grant;

  assign free_vec = ~busy;

  one_counter #(
    .DATA_WIDTH (N_ENTRY),
    .CNT_W      (CNT_W)
  ) u_free_cnt (
    .data_i  (free_vec),
    .count_o (free_cnt_o)
  );

  assign full_o    = (free_cnt_o == '0);
  assign empty_o   = (free_cnt_o == CNT_W'(N_ENTRY));
  assign rel_err_o = rel_err;

  // Lowest and second-lowest free entries in a single ascending scan.
  always_comb begin
    f0    = '0;
    f1    = '0;
    f0_ok = 1'b0;
    f1_ok = 1'b0;
    for (int unsigned i = 0; i < N_ENTRY; i++) begin
      if (free_vec[i]) begin
        if (!f0_ok) begin
          f0    = ID_W'(i);
          f0_ok = 1'b1;
        end else if (!f1_ok) begin
          f1    = ID_W'(i);
          f1_ok = 1'b1;
        end
      end
    end
  end

  assign both_vld = &alloc_vld_i;

  // Ready is offered to an idle requester too; its id is the candidate it would get.
  always_comb begin
    alloc_rdy_o = '0;
    id_ld       = f0;
    id_st       = f0;
    if (f1_ok) begin
      alloc_rdy_o = '1;
      if (both_vld) begin
        id_st = f1;
      end
    end else if (f0_ok) begin
      if (both_vld) begin
        alloc_rdy_o[rr_ptr] = 1'b1;
      end else begin
        alloc_rdy_o = '1;
      end
    end
  end

  assign alloc_id_o = {id_st, id_ld};
  assign grant      = alloc_rdy_o & alloc_vld_i;

  always_comb begin
    grant_oh = '0;
    rel_oh   = '0;
    for (int unsigned i = 0; i < N_ENTRY; i++) begin
      grant_oh[i] = (grant[REQ_LD] && (id_ld == ID_W'(i))) ||
                    (grant[REQ_ST] && (id_st == ID_W'(i)));
      rel_oh[i]   = rel_vld_i && (rel_id_i == ID_W'(i));
    end
  end

  // An out-of-range id matches no entry, so it lands in the error path.
  assign rel_hit  = |(rel_oh & busy);
  assign busy_nxt = (busy | grant_oh) & ~(rel_oh & busy);
  assign rr_nxt   = (both_vld && (^grant)) ? ~rr_ptr : rr_ptr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy    <= '0;
      rr_ptr  <= 1'b0;
      rel_err <= 1'b0;
    end else begin
      busy   <= busy_nxt;
      rr_ptr <= rr_nxt;
      if (rel_vld_i && !rel_hit) begin
        rel_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_l1d_mshr_alloc.sv
// Directed bench for l1d_mshr_alloc (N_ENTRY=8) with an expected-value queue.
module tb_l1d_mshr_alloc;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] alloc_vld_i;
  logic [1:0] alloc_rdy_o;
  logic [5:0] alloc_id_o;
  logic       rel_vld_i;
  logic [2:0] rel_id_i;
  logic [3:0] free_cnt_o;
  logic       full_o;
  logic       empty_o;
  logic       rel_err_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  l1d_mshr_alloc #(.N_ENTRY(8)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .alloc_vld_i (alloc_vld_i),
    .alloc_rdy_o (alloc_rdy_o),
    .alloc_id_o  (alloc_id_o),
    .rel_vld_i   (rel_vld_i),
    .rel_id_i    (rel_id_i),
    .free_cnt_o  (free_cnt_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .rel_err_o   (rel_err_o)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [31:0] v);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed %0d expected none", v);
    end else begin
      e = sb.pop_front();
      assert (v === e.val) else begin
        errors++;
        $error("FAIL %s observed %0d expected %0d", e.tag, v, e.val);
      end
    end
  endtask

  // Drive one cycle of inputs just after the edge, check combinational outputs, advance.
  task automatic step(input logic [1:0] vld, input logic rv, input logic [2:0] rid,
                      input logic [1:0] e_rdy, input logic chk_ids, input logic [5:0] e_ids,
                      input logic [3:0] e_free, input string tag);
    alloc_vld_i = vld;
    rel_vld_i   = rv;
    rel_id_i    = rid;
    expect_val({tag, "_rdy"}, 32'(e_rdy));
    if (chk_ids) expect_val({tag, "_id"}, 32'(e_ids));
    expect_val({tag, "_free"}, 32'(e_free));
    #2;
    observe(32'(alloc_rdy_o));
    if (chk_ids) observe(32'(alloc_id_o));
    observe(32'(free_cnt_o));
    @(posedge clk);
    #1;
  endtask

  task automatic flags(input logic e_full, input logic e_empty, input logic e_err,
                       input string tag);
    expect_val({tag, "_full"}, 32'(e_full));
    expect_val({tag, "_empty"}, 32'(e_empty));
    expect_val({tag, "_err"}, 32'(e_err));
    observe(32'(full_o));
    observe(32'(empty_o));
    observe(32'(rel_err_o));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn        = 1'b0;
    alloc_vld_i = 2'b00;
    rel_vld_i   = 1'b0;
    rel_id_i    = 3'd0;
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;

    flags(1'b0, 1'b1, 1'b0, "rst");
    // Fill: pairs (0,1),(2,3),(4,5),(6,7)
    step(2'b11, 1'b0, 3'd0, 2'b11, 1'b1, {3'd1, 3'd0}, 4'd8, "fill0");
    step(2'b11, 1'b0, 3'd0, 2'b11, 1'b1, {3'd3, 3'd2}, 4'd6, "fill1");
    step(2'b11, 1'b0, 3'd0, 2'b11, 1'b1, {3'd5, 3'd4}, 4'd4, "fill2");
    step(2'b11, 1'b0, 3'd0, 2'b11, 1'b1, {3'd7, 3'd6}, 4'd2, "fill3");
    flags(1'b1, 1'b0, 1'b0, "full");

    // Contention on a single free entry (3)
    step(2'b00, 1'b1, 3'd3, 2'b00, 1'b0, 6'd0,          4'd0, "rel3");
    step(2'b11, 1'b0, 3'd0, 2'b01, 1'b1, {3'd3, 3'd3}, 4'd1, "cont0");
    step(2'b11, 1'b1, 3'd3, 2'b00, 1'b0, 6'd0,          4'd0, "fullrel3");
    step(2'b11, 1'b0, 3'd0, 2'b10, 1'b1, {3'd3, 3'd3}, 4'd1, "cont1");

    // Full pool with release of 5: no grant that cycle, req0 next
    step(2'b11, 1'b1, 3'd5, 2'b00, 1'b0, 6'd0,          4'd0, "fullrel5");
    step(2'b11, 1'b0, 3'd0, 2'b01, 1'b1, {3'd5, 3'd5}, 4'd1, "grant5");

    // Release of a free entry sets the sticky error
    step(2'b00, 1'b1, 3'd2, 2'b00, 1'b0, 6'd0,          4'd0, "rel2");
    flags(1'b0, 1'b0, 1'b0, "prerr");
    step(2'b00, 1'b1, 3'd2, 2'b11, 1'b1, {3'd2, 3'd2}, 4'd1, "badrel2");
    flags(1'b0, 1'b0, 1'b1, "err");
    step(2'b00, 1'b1, 3'd4, 2'b11, 1'b0, 6'd0,          4'd1, "rel4");
    step(2'b10, 1'b0, 3'd0, 2'b11, 1'b1, {3'd2, 3'd2}, 4'd2, "st_only");
    step(2'b01, 1'b1, 3'd7, 2'b11, 1'b1, {3'd4, 3'd4}, 4'd1, "ld_rel7");
    step(2'b00, 1'b1, 3'd0, 2'b11, 1'b1, {3'd7, 3'd7}, 4'd1, "rel0");
    step(2'b00, 1'b1, 3'd1, 2'b11, 1'b1, {3'd0, 3'd0}, 4'd2, "rel1");
    flags(1'b0, 1'b0, 1'b1, "errhold");

    // Asynchronous reset in the middle of a granting cycle
    alloc_vld_i = 2'b11;
    rel_vld_i   = 1'b0;
    expect_val("pre_rst_rdy", 32'd3);
    expect_val("pre_rst_id", 32'({3'd1, 3'd0}));
    expect_val("pre_rst_free", 32'd3);
    #2;
    observe(32'(alloc_rdy_o));
    observe(32'(alloc_id_o));
    observe(32'(free_cnt_o));
    #1 rstn = 1'b0;
    #1;
    expect_val("async_rst_free", 32'd8);
    expect_val("async_rst_rdy", 32'd3);
    observe(32'(free_cnt_o));
    observe(32'(alloc_rdy_o));
    flags(1'b0, 1'b1, 1'b0, "async_rst");
    @(posedge clk);
    #3 begin
      rstn        = 1'b1;
      alloc_vld_i = 2'b00;
    end
    @(posedge clk);
    #1;

    // Round-robin pointer must be back at the load requester
    step(2'b11, 1'b0, 3'd0, 2'b11, 1'b1, {3'd1, 3'd0}, 4'd8, "post0");
    step(2'b11, 1'b0, 3'd0, 2'b11, 1'b1, {3'd3, 3'd2}, 4'd6, "post1");
    step(2'b11, 1'b0, 3'd0, 2'b11, 1'b1, {3'd5, 3'd4}, 4'd4, "post2");
    step(2'b01, 1'b0, 3'd0, 2'b11, 1'b1, {3'd6, 3'd6}, 4'd2, "post3");
    step(2'b11, 1'b0, 3'd0, 2'b01, 1'b1, {3'd7, 3'd7}, 4'd1, "post_cont");
    flags(1'b1, 1'b0, 1'b0, "post_full");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
